// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: AHB-lite HTRANS/HSIZE
// values and the data-phase owner state enum.
package mem_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Owner of the AHB data phase currently in flight.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA_I = 2'd1,
    ST_DATA_D = 2'd2
  } owner_e;

  // Load/store size code to HSIZE: a plain zero-extension of the 2-bit code.
  function automatic logic [2:0] hsize_of(input logic [1:0] size);
    case (size)
      2'd0:    hsize_of = HSIZE_BYTE;
      2'd1:    hsize_of = HSIZE_HALF;
      2'd2:    hsize_of = HSIZE_WORD;
      default: hsize_of = {1'b0, size};
    endcase
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way winner selection between the fetch (I) and load/store (D)
// requesters. Build option: MEM_PORT_ARB_FAIR_EN selects round-robin on a
// tie (the requester not granted last wins); otherwise D always wins.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic win_d
);

`ifdef MEM_PORT_ARB_FAIR_EN
  // On a tie, D wins unless D was the last one granted.
  assign win_d = d_req & (~i_req | ~last_d);
`else
  // Fixed priority: the data access belongs to the older instruction.
  logic unused_last_d;
  assign unused_last_d = last_d;
  assign win_d = d_req;
`endif

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// AHB-lite master. Address phase of the winner overlaps the data phase of
// the previous transfer; a wait counter flags a stalled slave on ERR.
// Build option: MEM_PORT_ARB_FAIR_EN enables round-robin tie breaking.
//
// Handshake: a requester holds REQ with its address; GNT (combinational,
// winner AND M_HREADY) marks the cycle its address is taken. Exactly one
// cycle with VALID high follows, in the first M_HREADY-high cycle of the
// data phase, with RDATA passed straight from M_HRDATA. REQ may change or
// drop freely before GNT.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_GNT,
  output logic        I_VALID,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [1:0]  D_SIZE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_GNT,
  output logic        D_VALID,
  output logic [31:0] D_RDATA,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY,
  output logic        ERR,
  output owner_e      DBG_STATE
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  owner_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
  logic [31:0]   hwdata_q;
  logic          active, win_d, last_d, stall;

  // Any request outside reset drives an address phase.
  assign active = (I_REQ | D_REQ) & ~RES;
  assign stall  = (state_q != ST_IDLE) & ~M_HREADY;

  arb_pick u_pick (
    .i_req  (I_REQ),
    .d_req  (D_REQ),
    .last_d (last_d),
    .win_d  (win_d)
  );

`ifdef MEM_PORT_ARB_FAIR_EN
  logic last_d_q;
  // Remember which requester took the most recent grant; resets to I.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                last_d_q <= 1'b0;
    else if (I_GNT | D_GNT) last_d_q <= win_d;
  end
  assign last_d = last_d_q;
`else
  assign last_d = 1'b0;
`endif

  assign I_GNT = active & ~win_d & M_HREADY;
  assign D_GNT = active &  win_d & M_HREADY;

  // Address-phase signals for the current winner, IDLE and zero otherwise.
  always_comb begin
    M_HTRANS = HTRANS_IDLE;
    M_HADDR  = '0;
    M_HWRITE = 1'b0;
    M_HSIZE  = '0;
    if (active) begin
      M_HTRANS = HTRANS_NONSEQ;
      if (win_d) begin
        M_HADDR  = D_ADDR;
        M_HWRITE = D_WE;
        M_HSIZE  = hsize_of(D_SIZE);
      end else begin
        M_HADDR  = I_ADDR;
        M_HSIZE  = HSIZE_WORD;
      end
    end
  end

  // Next data-phase owner: new grant, else idle once the slave is ready.
  always_comb begin
    state_d = state_q;
    if (I_GNT)         state_d = ST_DATA_I;
    else if (D_GNT)    state_d = ST_DATA_D;
    else if (M_HREADY) state_d = ST_IDLE;
  end

  // Wait counter: cleared on ready, saturating count of stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (M_HREADY)                      cnt_d = '0;
    else if (stall && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (stall && cnt_d == CNT_MAX);
    end
  end

  // Store data captured at D grant, held for the whole data phase.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)        hwdata_q <= '0;
    else if (D_GNT) hwdata_q <= D_WDATA;
  end

  assign M_HWDATA  = hwdata_q;
  assign I_VALID   = (state_q == ST_DATA_I) & M_HREADY & ~RES;
  assign D_VALID   = (state_q == ST_DATA_D) & M_HREADY & ~RES;
  assign I_RDATA   = M_HRDATA;
  assign D_RDATA   = M_HRDATA;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: driver issues vectors and pushes the
// expected VALID responses; a monitor pops and compares on every VALID.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        res;
  logic        i_req, d_req, d_we, m_hready;
  logic [31:0] i_addr, d_addr, d_wdata, m_hrdata;
  logic [1:0]  d_size;
  logic        i_gnt, i_valid, d_gnt, d_valid, m_hwrite, err;
  logic [31:0] i_rdata, d_rdata, m_haddr, m_hwdata;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  owner_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];  // {is_d, rdata}

  mem_port_arb #(.TIMEOUT(4)) dut (
    .CLK(clk), .RES(res),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_VALID(i_valid), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_SIZE(d_size), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(d_gnt), .D_VALID(d_valid), .D_RDATA(d_rdata),
    .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite), .M_HSIZE(m_hsize),
    .M_HWDATA(m_hwdata), .M_HRDATA(m_hrdata), .M_HREADY(m_hready),
    .ERR(err), .DBG_STATE(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every VALID consumes one expected response.
  always @(negedge clk) begin
    if (i_valid || d_valid) begin
      logic [32:0] e;
      if (i_valid && d_valid) check("dual_valid", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {30'd0, d_valid, i_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid_src", {31'd0, d_valid}, {31'd0, e[32]});
        check("rdata", d_valid ? d_rdata : i_rdata, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] tie_data [4];
    logic        tie_d    [4];
    tie_data[0] = 32'hA0A0A0A0; tie_data[1] = 32'hA1A1A1A1;
    tie_data[2] = 32'hA2A2A2A2; tie_data[3] = 32'hA3A3A3A3;
`ifdef MEM_PORT_ARB_FAIR_EN
    tie_d[0] = 1'b1; tie_d[1] = 1'b0; tie_d[2] = 1'b1; tie_d[3] = 1'b0;
`else
    tie_d[0] = 1'b1; tie_d[1] = 1'b1; tie_d[2] = 1'b1; tie_d[3] = 1'b1;
`endif

    // Reset with requests present: everything must read as reset values.
    res = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0040; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'd0; d_addr = '0; d_wdata = '0; m_hready = 1'b1; m_hrdata = '0;
    mid();
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_htrans", {30'd0, m_htrans}, {30'd0, HTRANS_IDLE});
    check("rst_haddr", m_haddr, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_err", {31'd0, err}, 32'd0);
    tick();
    res = 1'b0; i_req = 1'b0;

    // Single fetch: GNT in cycle n, VALID with data in n+1.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0100; m_hrdata = 32'hDEADBEEF;
    mid();
    check("f_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("f_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("f_htrans", {30'd0, m_htrans}, {30'd0, HTRANS_NONSEQ});
    check("f_haddr", m_haddr, 32'h0000_0100);
    check("f_hsize", {29'd0, m_hsize}, 32'd2);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    i_req = 1'b0;
    mid();
    check("f_idle_htrans", {30'd0, m_htrans}, {30'd0, HTRANS_IDLE});

    // Tie: D byte store wins first, I granted the cycle after.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h0000_0200;
    d_wdata = 32'h0000_0055; m_hrdata = 32'h11111111;
    mid();
    check("t_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("t_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("t_haddr", m_haddr, 32'h0000_0200);
    check("t_hsize", {29'd0, m_hsize}, 32'd0);
    check("t_hwrite", {31'd0, m_hwrite}, 32'd1);
    exp_q.push_back({1'b1, 32'h11111111});
    tick();
    d_req = 1'b0; d_wdata = 32'hAAAAAAAA;
    mid();
    check("t2_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("t2_hwdata", m_hwdata, 32'h0000_0055);
    check("t2_haddr", m_haddr, 32'h0000_0300);
    check("t2_hwrite", {31'd0, m_hwrite}, 32'd0);
    exp_q.push_back({1'b0, 32'h33333333});
    tick();
    i_req = 1'b0; m_hrdata = 32'h33333333;
    mid();

    // D load stalled 3 cycles; I requests meanwhile but must wait.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0400;
    mid();
    check("s_d_gnt", {31'd0, d_gnt}, 32'd1);
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0404;
    m_hready = 1'b0; m_hrdata = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("s_state", {30'd0, dbg_state}, {30'd0, ST_DATA_D});
      check("s_no_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
      check("s_no_valid", {31'd0, d_valid}, 32'd0);
      tick();
    end
    m_hready = 1'b1; m_hrdata = 32'hCAFEF00D;
    mid();
    check("s_i_gnt", {31'd0, i_gnt}, 32'd1);
    exp_q.push_back({1'b0, 32'h12345678});
    tick();
    i_req = 1'b0; m_hrdata = 32'h12345678;
    mid();
    check("s_state_i", {30'd0, dbg_state}, {30'd0, ST_DATA_I});
    check("s_err", {31'd0, err}, 32'd0);

    // Timeout of 4: ERR after the 4th low cycle, sticky afterwards.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0500;
    mid();
    check("e_i_gnt", {31'd0, i_gnt}, 32'd1);
    exp_q.push_back({1'b0, 32'h0BADF00D});
    tick();
    i_req = 1'b0; m_hready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("e_err_low", {31'd0, err}, 32'd0);
      tick();
    end
    m_hready = 1'b1; m_hrdata = 32'h0BADF00D;
    mid();
    check("e_err_set", {31'd0, err}, 32'd1);
    tick();
    mid();
    check("e_err_sticky", {31'd0, err}, 32'd1);

    // Reset pulsed during a fetch data phase: abandoned, never reported.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0600; m_hrdata = 32'h66666666;
    mid();
    check("r_i_gnt", {31'd0, i_gnt}, 32'd1);
    tick();
    res = 1'b1; d_req = 1'b1; d_we = 1'b1; d_size = 2'd1; d_addr = 32'h0000_0700;
    mid();
    check("r_i_valid", {31'd0, i_valid}, 32'd0);
    check("r_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    check("r_htrans", {30'd0, m_htrans}, {30'd0, HTRANS_IDLE});
    check("r_haddr", m_haddr, 32'd0);
    check("r_hwdata", m_hwdata, 32'd0);
    check("r_hwrite_hsize", {28'd0, m_hwrite, m_hsize}, 32'd0);
    check("r_err", {31'd0, err}, 32'd0);
    check("r_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    tick();
    res = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0800;
    mid();
    check("r_first_gnt", {31'd0, i_gnt}, 32'd1);
    exp_q.push_back({1'b0, 32'h77777777});
    tick();
    i_req = 1'b0; m_hrdata = 32'h77777777;
    mid();

    // Continuous tie: round-robin alternates D,I; fixed priority keeps D.
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0900;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0A00;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("rr_d_gnt", {31'd0, d_gnt}, {31'd0, tie_d[k]});
      check("rr_i_gnt", {31'd0, i_gnt}, {31'd0, ~tie_d[k]});
      exp_q.push_back({tie_d[k], tie_data[k]});
      tick();
      m_hrdata = tie_data[k];
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    mid();
    tick();
    mid();
    check("pending_valid", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of consecutive M_HREADY-low data-phase cycles that flags a bus error.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RES, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port I_REQ, input, 1 bit: instruction-fetch request.
REQ-005 SHALL have port I_ADDR, input, 32 bits: fetch address, word-aligned.
REQ-006 SHALL have port I_GNT, output, 1 bit: fetch address accepted this cycle.
REQ-007 SHALL have port I_VALID, output, 1 bit: the fetch data phase has completed this cycle.
REQ-008 SHALL have port I_RDATA, output, 32 bits: fetched word, meaningful only while I_VALID is high.
REQ-009 SHALL have port D_REQ, input, 1 bit: load/store request.
REQ-010 SHALL have port D_WE, input, 1 bit: 1 = store, 0 = load.
REQ-011 SHALL have port D_SIZE, input, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-012 SHALL have port D_ADDR, input, 32 bits; port D_WDATA, input, 32 bits.
REQ-013 SHALL have port D_GNT, output, 1 bit; port D_VALID, output, 1 bit; port D_RDATA, output, 32 bits; all with the same meaning as the I_ equivalents.
REQ-014 SHALL have port M_HADDR, output, 32 bits; M_HTRANS, output, 2 bits; M_HWRITE, output, 1 bit; M_HSIZE, output, 3 bits; M_HWDATA, output, 32 bits. These form the AHB-lite master port.
REQ-015 SHALL have port M_HRDATA, input, 32 bits, and port M_HREADY, input, 1 bit: slave read data and ready.
REQ-016 SHALL have port ERR, output, 1 bit: sticky timeout flag.

Function
REQ-017 SHALL implement the AHB-lite two-phase protocol: an address phase for the granted requester, overlapped with the data phase of the previous transfer.
REQ-018 SHALL, in a cycle with any request, drive M_HTRANS = NONSEQ (2'b10) with the winner's address, write flag and size; otherwise it SHALL drive IDLE (2'b00).
REQ-019 SHALL extend D_SIZE to M_HSIZE by zero-extension; I transfers SHALL use M_HSIZE = 3'b010.
REQ-020 SHALL compute I_GNT and D_GNT combinationally as (winner AND M_HREADY); at most one grant SHALL be high per cycle.
REQ-021 SHALL use fixed priority: D wins over I when both request (the data access is the older instruction).
REQ-022 SHALL track a data-phase owner in a state machine with states IDLE, DATA_I and DATA_D.
- On a grant, the next state is DATA_I or DATA_D according to the winner.
- With M_HREADY high and no grant, the next state is IDLE.
- With M_HREADY low, the state holds.
REQ-023 SHALL register D_WDATA at D_GNT and drive it on M_HWDATA throughout the following data phase.
REQ-024 SHALL assert the owner's VALID for exactly one cycle when M_HREADY is high in DATA_I or DATA_D, with RDATA = M_HRDATA passed through unregistered.
- Minimum latency is GNT in cycle n, VALID in cycle n+1.
- Back-to-back transfers SHALL sustain one per cycle.
REQ-025 SHALL accept a requester that changes address or drops its request before its grant without error; it is not required to hold the request.
REQ-026 SHALL count consecutive M_HREADY-low cycles in DATA_I or DATA_D, saturating.
- When the count reaches TIMEOUT, ERR SHALL set and remain set until reset.
- The transfer continues to wait for M_HREADY.
REQ-027 SHALL clear the wait counter on every M_HREADY-high cycle.

Reset
REQ-028 SHALL, while RES is high, immediately force the following, regardless of any transfer in flight; the abandoned data phase is never reported:
- State IDLE.
- Counter 0.
- ERR = 0.
- M_HTRANS = IDLE.
- M_HADDR, M_HWDATA, M_HWRITE and M_HSIZE = 0.
- All GNT and VALID = 0.
REQ-029 SHALL permit grants from the first rising edge after RES deasserts.

Configuration
REQ-030 SHALL, with macro MEM_PORT_ARB_FAIR_EN defined, replace fixed priority with round-robin.
- A last-winner flag updates on each grant.
- On simultaneous requests, the requester not granted last wins.
- The flag resets to I, so D wins the first tie.
REQ-031 SHALL, without MEM_PORT_ARB_FAIR_EN, behave exactly per REQ-021 and contain no last-winner flag.

Structure
REQ-032 SHALL take the following from shared package mem_arb_pkg: the HTRANS encodings (IDLE, NONSEQ), the HSIZE encodings, and the owner-state enum.
REQ-033 SHALL place the two-way winner selection in sub-module arb_pick (inputs: both requests and the last winner; output: winner), so that the macro affects only that sub-module.

Verification
REQ-034 SHALL verify: I_REQ alone at 0x100, M_HREADY = 1, M_HRDATA = 0xDEADBEEF -> I_GNT in cycle n, I_VALID with I_RDATA = 0xDEADBEEF in cycle n+1.
REQ-035 SHALL verify: I_REQ and D_REQ together, D store 0x55 to 0x200 as a byte -> D_GNT first, M_HSIZE = 0, M_HWDATA = 0x55 in the next cycle; I_GNT one cycle later.
REQ-036 SHALL verify: a D load with M_HREADY low for 3 cycles -> state holds in DATA_D, one D_VALID after M_HREADY rises, no overlapping grant while stalled.
REQ-037 SHALL verify: TIMEOUT = 4 with M_HREADY low for 4 cycles -> ERR rises on the 4th and stays high after M_HREADY returns.
REQ-038 SHALL verify: RES pulsed during DATA_I -> outputs at reset values immediately, no I_VALID afterwards.
REQ-039 SHALL verify: with MEM_PORT_ARB_FAIR_EN and I and D requesting continuously -> grants alternate D, I, D, I.
